pico_load_ctrl: RTL
===================

PICO_LOAD_CTRL -- requirements
Module: pico_load_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, the program BRAM address width.
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, the number of cycles the processor stays in reset after a load ends (legal range 1..255).
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all state SHALL be on the rising edge of clk.
REQ-004 clk  in  1  system clock; jtag-side and processor-side inputs are synchronous to it.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 jtag_en  in  1  loader BRAM access enable.
REQ-007 jtag_we  in  1  loader write strobe, qualified by jtag_en.
REQ-008 jtag_addr  in  ADDR_WIDTH  loader address.
REQ-009 jtag_din  in  18  loader write data.
REQ-010 jtag_rst  in  1  loader processor-reset request.
REQ-011 jtag_dout  out  18  loader readback data.
REQ-012 cpu_address  in  ADDR_WIDTH  processor instruction address.
REQ-013 cpu_bram_enable  in  1  processor fetch enable.
REQ-014 cpu_instruction  out  18  fetched instruction.
REQ-015 cpu_reset  out  1  active-high processor reset.
REQ-016 bram_en, bram_we  out  1 each  BRAM port controls.
REQ-017 bram_addr  out  ADDR_WIDTH; bram_din  out  18; bram_dout  in  18 (1-cycle read latency).
REQ-018 load_done  out  1  one-cycle pulse at end of a load session.
REQ-019 word_count  out  ADDR_WIDTH+1  writes counted in the current/last session.
REQ-020 checksum  out  18  sum modulo 2^18 of words written in the current/last session.

Function
REQ-021 States: HOLD, RUN, LOAD; a request is jtag_en=1 or jtag_rst=1.
REQ-022 HOLD: count 0..HOLD_CYCLES-1; a request goes to LOAD; otherwise, after HOLD_CYCLES cycles, goes to RUN.
REQ-023 RUN: a request goes to LOAD; otherwise stays in RUN.
REQ-024 LOAD: stays while a request is present; the first cycle with no request goes to HOLD with the counter cleared and load_done=1 for exactly that cycle.
REQ-025 A HOLD->LOAD transition SHALL NOT pulse load_done.
REQ-026 BRAM owner is the loader when state=LOAD or a request is present (combinational, so the first loader access is never lost); otherwise it is the processor.
REQ-027 Loader ownership: bram_en=jtag_en, bram_we=jtag_en&jtag_we, bram_addr=jtag_addr, bram_din=jtag_din.
REQ-028 Processor ownership in RUN: bram_en=cpu_bram_enable, bram_we=0, bram_addr=cpu_address, bram_din=0.
REQ-029 Processor ownership in HOLD: bram_en=0, bram_we=0.
REQ-030 jtag_dout and cpu_instruction SHALL both equal bram_dout.
REQ-031 cpu_reset=1 unless state=RUN with no request present.
REQ-032 On the session-entry cycle (state not LOAD, request present), word_count SHALL load 1 and checksum SHALL load jtag_din if a loader write occurs; otherwise both load 0.
REQ-033 In LOAD, each loader write SHALL increment word_count and add jtag_din to checksum (modulo 2^18).
REQ-034 word_count SHALL saturate at 2^ADDR_WIDTH.
REQ-035 word_count and checksum SHALL hold their values outside LOAD and the entry cycle.
REQ-036 A jtag_en=1, jtag_we=0 cycle is a read: it changes neither word_count nor checksum.

Reset
REQ-037 While rst_n=0: state=HOLD, hold counter=0, load_done=0, word_count=0, checksum=0, cpu_reset=1.
REQ-038 Ownership outputs remain combinational during reset; with no request present, bram_en=0 and bram_we=0.
REQ-039 Reset asserted mid-LOAD SHALL abort the session with no load_done pulse.

Verification
REQ-040 Release rst_n, no requests -> cpu_reset=1 for exactly 16 cycles, then 0; state=RUN; processor fetches reach BRAM.
REQ-041 In RUN, jtag_rst=1, then 3 writes of 0x00001, 0x00002, 0x3FFFF, then idle -> cpu_reset=1 throughout; load_done pulses once; word_count=3; checksum=0x00002; cpu_reset releases 16 cycles after the pulse.
REQ-042 jtag_en=1 with jtag_we=0 while cpu_bram_enable=1 in RUN -> BRAM driven by jtag_addr in the same cycle; bram_we=0; counters unchanged.
REQ-043 Write all 1024 addresses, then one extra write -> word_count=1024, saturated.
REQ-044 New request at HOLD cycle 5 -> LOAD with no load_done pulse; counters restart from the entry-cycle value.
REQ-045 rst_n low mid-LOAD -> all counters 0, cpu_reset=1, no load_done pulse.

Source files
------------

// File: rtl/pico_load_ctrl.sv
// pico_load_ctrl
// Arbitrates a single-port program BRAM between a JTAG program loader and
// a small soft processor, and sequences the processor reset around loads.
//
// States:
//   HOLD | processor held in reset, counting HOLD_CYCLES before release
//   RUN  | processor running, owns the BRAM for instruction fetch
//   LOAD | loader session active, loader owns the BRAM
//
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   jtag_en/we/addr/din/rst    loader access and processor-reset request
//   jtag_dout                  loader readback (BRAM read data)
//   cpu_address/bram_enable    processor fetch port
//   cpu_instruction            fetched instruction (BRAM read data)
//   cpu_reset                  active-high processor reset
//   bram_en/we/addr/din/dout   BRAM port (1-cycle read latency)
//   load_done                  one-cycle pulse when a load session ends
//   word_count, checksum       write count / sum of the current or last session
module pico_load_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jtag_en,
  input  logic                  jtag_we,
  input  logic [ADDR_WIDTH-1:0] jtag_addr,
  input  logic [17:0]           jtag_din,
  input  logic                  jtag_rst,
  output logic [17:0]           jtag_dout,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_bram_enable,
  output logic [17:0]           cpu_instruction,
  output logic                  cpu_reset,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [17:0]           bram_din,
  input  logic [17:0]           bram_dout,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [17:0]           checksum
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam logic [7:0]          HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] WC_MAX    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] WC_ONE    = (ADDR_WIDTH+1)'(1);

  state_t                state_q, state_d;
  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic                  load_done_q, load_done_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic [17:0]           checksum_q, checksum_d;

  logic req;
  logic wr;
  logic loader_owns;

  assign req = jtag_en | jtag_rst;
  assign wr  = jtag_en & jtag_we;
  // Ownership follows the raw request so the loader's first access, made on
  // the same cycle the request appears, is not lost to the processor.
  assign loader_owns = (state_q == ST_LOAD) | req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= '0;
      load_done_q  <= 1'b0;
      word_count_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      load_done_q  <= load_done_d;
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    load_done_d = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (req) begin
          state_d    = ST_LOAD;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (req) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!req) begin
          state_d     = ST_HOLD;
          hold_cnt_d  = '0;
          // Registered, so the pulse lines up with the first HOLD cycle.
          load_done_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    word_count_d = word_count_q;
    checksum_d   = checksum_q;
    if (state_q != ST_LOAD && req) begin
      // Session entry restarts the statistics, counting an entry-cycle write.
      word_count_d = wr ? WC_ONE : '0;
      checksum_d   = wr ? jtag_din : '0;
    end else if (state_q == ST_LOAD && wr) begin
      if (word_count_q != WC_MAX) word_count_d = word_count_q + WC_ONE;
      checksum_d = checksum_q + jtag_din;
    end
  end

  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = cpu_address;
    bram_din  = '0;
    if (loader_owns) begin
      bram_en   = jtag_en;
      bram_we   = wr;
      bram_addr = jtag_addr;
      bram_din  = jtag_din;
    end else if (state_q == ST_RUN) begin
      bram_en   = cpu_bram_enable;
      bram_addr = cpu_address;
    end
  end

  assign jtag_dout       = bram_dout;
  assign cpu_instruction = bram_dout;
  assign cpu_reset       = !((state_q == ST_RUN) && !req);
  assign load_done       = load_done_q;
  assign word_count      = word_count_q;
  assign checksum        = checksum_q;

endmodule
